phy_tx_sched: RTL and testbench



---
 rtl/phy_tx_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 21 ++
 rtl/phy_tx_sched.sv | 150 +++++++++++++++
 tb/tb_phy_tx_sched.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/phy_tx_pkg.sv
// Shared types and link constants for the phy_tx transmit scheduler.
package phy_tx_pkg;

  typedef enum logic [1:0] {
    ST_TRAIN  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  localparam logic [31:0] TRAIN_WORD = 32'hBCBCBCBC;
  localparam logic [31:0] IDLE_WORD  = 32'h7C7C7C7C;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; last names the lane granted most recently.
module rr_arbiter2 (
  input  logic       enable,
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/phy_tx_sched.sv
// Training burst then round-robin word scheduler in front of phy_tx.
// Define PHY_TX_SCHED_STATS_EN to add per-requester transfer counters.
module phy_tx_sched
  import phy_tx_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TRAIN_WORDS = 4
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              tx_enable,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  output logic [DATA_W-1:0] entrada,
  output logic              valid,
  output logic              selector_tx,
`ifdef PHY_TX_SCHED_STATS_EN
  output logic [15:0]       cnt0,
  output logic [15:0]       cnt1,
`endif
  output logic              trained
);

  localparam int CW = (TRAIN_WORDS > 2) ? $clog2(TRAIN_WORDS) : 1;
  localparam logic [CW-1:0] TLAST = CW'(TRAIN_WORDS - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     tcnt_q, tcnt_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] entrada_q, entrada_d;
  logic              valid_q, valid_d;
  logic              sel_q, sel_d;
  logic              trained_q, trained_d;
  logic [1:0]        gnt;
  logic              arb_en;

  // Reset masks grants so nothing transfers in the reset cycle.
  assign arb_en = tx_enable & ~reset & (state_q == ST_ACTIVE);

  rr_arbiter2 u_arb (
    .enable (arb_en),
    .req    ({req1_valid, req0_valid}),
    .last   (last_q),
    .gnt    (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state_q <= ST_TRAIN;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      ST_TRAIN: begin
        if (tx_enable) begin
          tcnt_d = tcnt_q + CW'(1);
          if (tcnt_q == TLAST) begin
            tcnt_d  = '0;
            state_d = ST_ACTIVE;
          end
        end
      end
      ST_ACTIVE: if (!tx_enable) state_d = ST_HOLD;
      ST_HOLD:   if (tx_enable) state_d = ST_ACTIVE;
      default:   state_d = ST_TRAIN;
    endcase
  end

  always_comb begin
    entrada_d = DATA_W'(IDLE_WORD);
    valid_d   = 1'b0;
    sel_d     = sel_q;
    trained_d = trained_q;
    last_d    = last_q;
    unique case (1'b1)
      (state_q == ST_TRAIN) && tx_enable: begin
        entrada_d = DATA_W'(TRAIN_WORD);
        valid_d   = 1'b1;
        sel_d     = tcnt_q[0];
        if (tcnt_q == TLAST) trained_d = 1'b1;
      end
      gnt[0]: begin
        entrada_d = req0_data;
        valid_d   = 1'b1;
        sel_d     = LANE0;
        last_d    = LANE0;
      end
      gnt[1]: begin
        entrada_d = req1_data;
        valid_d   = 1'b1;
        sel_d     = LANE1;
        last_d    = LANE1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      entrada_q <= DATA_W'(IDLE_WORD);
      valid_q   <= 1'b0;
      sel_q     <= LANE0;
      trained_q <= 1'b0;
      last_q    <= LANE1;
    end else begin
      entrada_q <= entrada_d;
      valid_q   <= valid_d;
      sel_q     <= sel_d;
      trained_q <= trained_d;
      last_q    <= last_d;
    end
  end

  assign entrada     = entrada_q;
  assign valid       = valid_q;
  assign selector_tx = sel_q;
  assign trained     = trained_q;

`ifdef PHY_TX_SCHED_STATS_EN
  logic [15:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (gnt[0] && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
      if (gnt[1] && cnt1_q != 16'hFFFF) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_phy_tx_sched.sv
// Directed bench for phy_tx_sched with a cycle model and literal pins.
module tb_phy_tx_sched;

  localparam int TW = 4;
  localparam logic [31:0] TRN = 32'hBCBCBCBC;
  localparam logic [31:0] IDL = 32'h7C7C7C7C;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_enable;
  logic [31:0] req0_data, req1_data;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] entrada;
  logic        valid, selector_tx, trained;
`ifdef PHY_TX_SCHED_STATS_EN
  logic [15:0] cnt0, cnt1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  phy_tx_sched #(.DATA_W(32), .TRAIN_WORDS(TW)) dut (
    .clk_2f      (clk),
    .reset       (reset),
    .tx_enable   (tx_enable),
    .req0_data   (req0_data),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req1_data   (req1_data),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .entrada     (entrada),
    .valid       (valid),
    .selector_tx (selector_tx),
`ifdef PHY_TX_SCHED_STATS_EN
    .cnt0        (cnt0),
    .cnt1        (cnt1),
`endif
    .trained     (trained)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model state: words of training already sent, pause flag, pointer.
  int          m_sent = 0;
  bit          m_hold = 0;
  int          m_last = 1;
  int          m_c0 = 0, m_c1 = 0;
  bit          have_exp = 0;
  logic [31:0] e_ent;
  logic        e_val, e_sel, e_tr;

  always @(negedge clk) begin
    int w;
    if (have_exp) begin
      chk("m_entrada", entrada, e_ent);
      chk("m_valid", 32'(valid), 32'(e_val));
      chk("m_sel", 32'(selector_tx), 32'(e_sel));
      chk("m_trained", 32'(trained), 32'(e_tr));
`ifdef PHY_TX_SCHED_STATS_EN
      chk("m_cnt0", 32'(cnt0), m_c0);
      chk("m_cnt1", 32'(cnt1), m_c1);
`endif
    end
    w = -1;
    if (!reset && m_sent >= TW && !m_hold && tx_enable) begin
      if (req0_valid && req1_valid) w = (m_last == 1) ? 0 : 1;
      else if (req0_valid) w = 0;
      else if (req1_valid) w = 1;
    end
    chk("m_ready0", 32'(req0_ready), 32'(w == 0));
    chk("m_ready1", 32'(req1_ready), 32'(w == 1));
    if (reset) begin
      e_ent = IDL; e_val = 0; e_sel = 0; e_tr = 0;
      m_sent = 0; m_hold = 0; m_last = 1;
      m_c0 = 0; m_c1 = 0;
      have_exp = 1;
    end else if (m_sent < TW) begin
      if (tx_enable) begin
        e_ent = TRN; e_val = 1; e_sel = m_sent[0];
        m_sent++;
        e_tr = (m_sent == TW);
      end else begin
        e_ent = IDL; e_val = 0;
      end
    end else if (w >= 0) begin
      e_ent = (w == 1) ? req1_data : req0_data;
      e_val = 1; e_sel = w[0]; m_last = w;
      if (w == 0 && m_c0 < 65535) m_c0++;
      if (w == 1 && m_c1 < 65535) m_c1++;
    end else begin
      e_ent = IDL; e_val = 0;
      if (m_hold && tx_enable) m_hold = 0;
      else if (!m_hold && !tx_enable) m_hold = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [31:0] ent,
                     input logic v, input logic s);
    chk({nm, "_ent"}, entrada, ent);
    chk({nm, "_val"}, 32'(valid), 32'(v));
    chk({nm, "_sel"}, 32'(selector_tx), 32'(s));
  endtask

  initial begin
    reset = 1; tx_enable = 0;
    req0_valid = 0; req1_valid = 0;
    req0_data = '0; req1_data = '0;
    step(); step();
    lit("rst", IDL, 0, 0);
    chk("rst_trained", 32'(trained), 0);

    reset = 0; tx_enable = 1;
    req0_valid = 1; req0_data = 32'hFFFFFFFF;
    #1 chk("train_rdy0", 32'(req0_ready), 0);
    for (int i = 0; i < TW; i++) begin
      step();
      lit("train", TRN, 1, i[0]);
      chk("train_trained", 32'(trained), 32'(i == TW - 1));
      if (i < TW - 1) chk("train_rdy", 32'(req0_ready), 0);
    end
    #1 chk("t2_rdy0", 32'(req0_ready), 1);
    step();
    lit("t2", 32'hFFFFFFFF, 1, 0);

    req0_valid = 0; req1_valid = 1; req1_data = 32'h12345678;
    step();
    lit("r1only", 32'h12345678, 1, 1);

    req0_valid = 1; req0_data = 32'hEEEEEEEE; req1_data = 32'hDDDDDDDD;
    for (int k = 0; k < 4; k++) begin
      step();
      lit("rr", k[0] ? 32'hDDDDDDDD : 32'hEEEEEEEE, 1, k[0]);
    end

    req0_valid = 0; req1_valid = 0;
    step();
    lit("idle", IDL, 0, 1);

    req0_valid = 1; req1_valid = 1; tx_enable = 0;
    #1 chk("hold_rdy", {30'd0, req1_ready, req0_ready}, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      lit("hold", IDL, 0, 1);
    end
    tx_enable = 1;
    step();
    chk("resume_val", 32'(valid), 0);
    #1 chk("resume_rdy", {30'd0, req1_ready, req0_ready}, 32'd1);
    step();
    lit("resume", 32'hEEEEEEEE, 1, 0);
    step();
    lit("resume2", 32'hDDDDDDDD, 1, 1);
`ifdef PHY_TX_SCHED_STATS_EN
    chk("cnt0_lit", 32'(cnt0), 4);
    chk("cnt1_lit", 32'(cnt1), 4);
`endif

    reset = 1;
    #1 chk("rstmid_rdy", {30'd0, req1_ready, req0_ready}, 0);
    step();
    lit("rstmid", IDL, 0, 0);
    chk("rstmid_trained", 32'(trained), 0);
`ifdef PHY_TX_SCHED_STATS_EN
    chk("rstmid_cnt", {cnt1, cnt0}, 0);
`endif

    reset = 0;
    step(); lit("retrain0", TRN, 1, 0);
    step(); lit("retrain1", TRN, 1, 1);
    tx_enable = 0;
    step();
    lit("trainpause", IDL, 0, 1);
    chk("trainpause_tr", 32'(trained), 0);
    tx_enable = 1;
    step(); lit("retrain2", TRN, 1, 0);
    step(); lit("retrain3", TRN, 1, 1);
    chk("retrain_tr", 32'(trained), 1);
    step();
    lit("post_rst", 32'hEEEEEEEE, 1, 0);
    step();
    lit("post_rst2", 32'hDDDDDDDD, 1, 1);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
